// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered W-bit ALU with a valid/ready handshake.
//
// Sits between the register file and the writeback mux. It computes one
// operation per accepted request and registers the result and the flags.
// Ops 000-110 always finish in a single cycle. Op 111 is either a
// multi-cycle shift-and-add multiply or a single-cycle bitwise NOT,
// depending on the build option below.
//
// Build option:
//   ALU_SEQ_MUL_EN  defined   : op 111 = unsigned multiply. It takes W
//                               iteration cycles and then one result cycle.
//                   undefined : no multiplier. op 111 = ~A in one cycle,
//                               and busy is tied to 0.
//
// Parameters:
//   W      datapath width (4..32)
//   CNT_W  multiply iteration counter width, $clog2(W)+1 (derived; present
//          only when the multiplier is built)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   in_valid   operands/opcode present this cycle
//   in_ready   an operation can be accepted (= ~busy)
//   A, B       operands (W bits)
//   c_in       carry in, used by ADD only
//   op         3-bit opcode
//   R          registered result
//   out_valid  one-cycle pulse: R and flags were updated this cycle
//   zero       R == 0
//   c_out      carry / no-borrow / multiply high-half-nonzero
//   sign       R[W-1]
//   ovf        signed overflow (multiply: same as c_out)
//   busy       multiply in progress
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         c_in,
    input  logic [2:0]   op,
    output logic [W-1:0] R,
    output logic         out_valid,
    output logic         zero,
    output logic         c_out,
    output logic         sign,
    output logic         ovf,
    output logic         busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Result of one operation, before it is registered.
    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } alu_rsp_t;

    logic accept;
    assign accept   = in_valid & in_ready;
    assign in_ready = ~busy;

    // -------------------------------------------------------------------------
    // Single-cycle datapath
    // -------------------------------------------------------------------------
    logic [W:0]   sum_add;
    logic [W:0]   sum_sub;
    logic [W:0]   sum_inc;
    logic [W-1:0] neg_res;
    alu_rsp_t     sc_rsp;

    // The extra top bit of each sum is the carry out of bit W-1.
    assign sum_add = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, c_in};
    assign sum_sub = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
    assign sum_inc = {1'b0, A} + {{W{1'b0}}, 1'b1};
    assign neg_res = (~A) + {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        sc_rsp = '0;
        case (op)
            OP_ADD: begin
                sc_rsp.res = sum_add[W-1:0];
                sc_rsp.c   = sum_add[W];
                // Operands share a sign and the result sign differs.
                sc_rsp.v   = (A[W-1] == B[W-1]) && (sum_add[W-1] != A[W-1]);
            end
            OP_SUB: begin
                sc_rsp.res = sum_sub[W-1:0];
                sc_rsp.c   = sum_sub[W];            // 1 = no borrow
                // A + ~B: the effective second operand has the sign ~B[W-1].
                sc_rsp.v   = (A[W-1] != B[W-1]) && (sum_sub[W-1] != A[W-1]);
            end
            OP_INC: begin
                sc_rsp.res = sum_inc[W-1:0];
                sc_rsp.c   = sum_inc[W];
                sc_rsp.v   = ~A[W-1] & sum_inc[W-1];
            end
            OP_NEG: begin
                sc_rsp.res = neg_res;
                sc_rsp.c   = (A == '0);
                // Only the most negative value negates to itself.
                sc_rsp.v   = A[W-1] & neg_res[W-1];
            end
            OP_AND:  sc_rsp.res = A & B;
            OP_OR:   sc_rsp.res = A | B;
            OP_XOR:  sc_rsp.res = A ^ B;
`ifdef ALU_SEQ_MUL_EN
            // Handled by the multiplier below, never by this path.
            OP_MUL:  sc_rsp = '0;
`else
            OP_MUL:  sc_rsp.res = ~A;
`endif
            default: sc_rsp = '0;
        endcase
    end

    // Write port into the result/flag registers.
    logic     wr_en;
    alu_rsp_t wr_rsp;

`ifdef ALU_SEQ_MUL_EN
    // -------------------------------------------------------------------------
    // Shift-and-add multiplier
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   prod;      // {partial sum, remaining multiplier bits}
    logic [W-1:0]     mcand;
    logic [W:0]       part;
    logic [2*W-1:0]   prod_nxt;
    logic             mul_start;
    logic             mul_last;

    assign mul_start = accept && (op == OP_MUL);
    assign mul_last  = (state == S_MUL) && (cnt == CNT_W'(W - 1));

    // One partial product per cycle: add the multiplicand into the upper
    // half when the current multiplier LSB is set, then shift right. After
    // W steps, prod holds the full 2W-bit product.
    assign part     = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_nxt = {part, prod[W-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                prod  <= {{W{1'b0}}, B};
                mcand <= A;
                cnt   <= '0;
            end else if (state == S_MUL) begin
                prod  <= prod_nxt;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    // DONE is the out_valid cycle. The product is written into R on the
    // edge that enters DONE, so R changes only on the cycle that out_valid
    // is high. DONE is not busy, so a new operation can be accepted there.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_DONE: state_nxt = mul_start ? S_MUL : S_IDLE;
            S_MUL: begin
                busy = 1'b1;
                if (mul_last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accept and the last multiply step never occur together, because
    // in_ready is low in S_MUL.
    always_comb begin
        wr_en  = 1'b0;
        wr_rsp = sc_rsp;
        if (accept && (op != OP_MUL)) begin
            wr_en = 1'b1;
        end else if (mul_last) begin
            wr_en      = 1'b1;
            wr_rsp.res = prod_nxt[W-1:0];
            wr_rsp.c   = |prod_nxt[2*W-1:W];
            wr_rsp.v   = |prod_nxt[2*W-1:W];
        end
    end
`else
    assign busy   = 1'b0;
    assign wr_en  = accept;
    assign wr_rsp = sc_rsp;
`endif

    // -------------------------------------------------------------------------
    // Result and flag registers. They hold between out_valid pulses.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            R         <= '0;
            zero      <= 1'b0;
            c_out     <= 1'b0;
            sign      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= wr_en;
            if (wr_en) begin
                R     <= wr_rsp.res;
                zero  <= (wr_rsp.res == '0);
                c_out <= wr_rsp.c;
                sign  <= wr_rsp.res[W-1];
                ovf   <= wr_rsp.v;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed plus short random bench for alu_seq (W=8).
// Expected results are pushed to a queue when an operation is driven. A
// negedge monitor pops one entry for every out_valid pulse and compares it.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         c_in = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready;
    logic [W-1:0] R;
    logic         out_valid, zero, c_out, sign, ovf, busy;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .c_in      (c_in),
        .op        (op),
        .R         (R),
        .out_valid (out_valid),
        .zero      (zero),
        .c_out     (c_out),
        .sign      (sign),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       s;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   ov_seen = 0;
    int   ov_before = 0;
    int   busy_cnt = 0;
    int   ov_at = 0;
    logic [7:0] b2b_exp [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic c, input logic v);
        exp_t e;
        e.r = r;
        e.z = (r == 8'h00);
        e.c = c;
        e.s = r[7];
        e.v = v;
        return e;
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] a,
                                   input logic [7:0] b, input logic ci);
        int ua, ub, sa, sbv, t, st;
        logic [7:0] r;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sbv = int'($signed(b));
        t = 0; st = 0; c = 1'b0; v = 1'b0;
        case (o)
            3'd0: begin t = ua + ub + int'(ci); st = sa + sbv + int'(ci); c = (t > 255); end
            3'd1: begin t = ua - ub; st = sa - sbv; c = (ua >= ub); end
            3'd2: begin t = ua + 1; st = sa + 1; c = (t > 255); end
            3'd3: begin t = -ua; st = -sa; c = (ua == 0); end
            3'd4: t = ua & ub;
            3'd5: t = ua | ub;
            3'd6: t = ua ^ ub;
            default: begin
`ifdef ALU_SEQ_MUL_EN
                t = ua * ub; c = (t > 255); v = c;
`else
                t = ua ^ 255;
`endif
            end
        endcase
        if (o <= 3'd3) v = (st > 127) || (st < -128);
        r = t[7:0];
        return mk(r, c, v);
    endfunction

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input exp_t e, input bit push);
        @(negedge clk);
        in_valid = 1'b1;
        op = o; A = a; B = b; c_in = ci;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            ov_seen++;
            chk("ov_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("R", R, cur.r);
                chk("flags_zcsv", {zero, c_out, sign, ovf}, {cur.z, cur.c, cur.s, cur.v});
            end
        end
    end

    initial begin
        b2b_exp[0] = 8'h30; b2b_exp[1] = 8'hFC; b2b_exp[2] = 8'hCC;

        // Reset state
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_R", R, 0);
        chk("rst_zero", zero, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_sign", sign, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;

        // Reset asserted mid-stream
        issue(3'd0, 8'h01, 8'h02, 1'b0, mk(8'h03, 1'b0, 1'b0), 1);
        issue(3'd0, 8'h03, 8'h04, 1'b0, mk(8'h07, 1'b0, 1'b0), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_R", R, 0);
        chk("mid_rst_flags", {zero, c_out, sign, ovf}, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_R", R, 0);

        // ADD with wraparound; out_valid lasts exactly one cycle
        issue(3'd0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0), 1);
        idle();
        chk("add_ov_pulse", out_valid, 1);
        @(negedge clk);
        chk("add_ov_single", out_valid, 0);
        chk("add_R_hold", R, 8'h00);

        // SUB overflow and borrow
        issue(3'd1, 8'h80, 8'h01, 1'b0, mk(8'h7F, 1'b1, 1'b1), 1);
        issue(3'd1, 8'h01, 8'h02, 1'b0, mk(8'hFF, 1'b0, 1'b0), 1);
        // Edge cases for INC / NEG / ADD carry-in / SUB ignores c_in
        issue(3'd2, 8'h7F, 8'h00, 1'b0, mk(8'h80, 1'b0, 1'b1), 1);
        issue(3'd2, 8'hFF, 8'h00, 1'b0, mk(8'h00, 1'b1, 1'b0), 1);
        issue(3'd3, 8'h00, 8'h00, 1'b0, mk(8'h00, 1'b1, 1'b0), 1);
        issue(3'd0, 8'h7F, 8'h00, 1'b1, mk(8'h80, 1'b0, 1'b1), 1);
        issue(3'd1, 8'h05, 8'h05, 1'b0, mk(8'h00, 1'b1, 1'b0), 1);
        issue(3'd1, 8'h05, 8'h03, 1'b1, mk(8'h02, 1'b1, 1'b0), 1);
        idle();
        @(negedge clk);

        // Back-to-back AND/OR/XOR
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) chk("b2b_out_valid", out_valid, 1);
            if (i < 3) begin
                in_valid = 1'b1;
                op = 3'(4 + i); A = 8'hF0; B = 8'h3C; c_in = 1'b0;
                exp_q.push_back(mk(b2b_exp[i], 1'b0, 1'b0));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_ov_end", out_valid, 0);

        // Random single-cycle ops, back-to-back
        for (int i = 0; i < 16; i++) begin
            logic [2:0] o;
            logic [7:0] a, b;
            logic ci;
            o = 3'($urandom_range(0, 6));
            a = 8'($urandom);
            b = 8'($urandom);
            ci = 1'($urandom);
            issue(o, a, b, ci, model(o, a, b, ci), 1);
        end
        idle();
        repeat (2) @(negedge clk);

`ifdef ALU_SEQ_MUL_EN
        // MUL: busy for W cycles, result on cycle W+1, input during busy ignored
        issue(3'd7, 8'h10, 8'h11, 1'b0, mk(8'h10, 1'b1, 1'b1), 1);
        busy_cnt = 0; ov_at = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1 && ov_at == 0) ov_at = k;
            if (k == 2) chk("mul_in_ready_low", in_ready, 0);
            if (k == 1) in_valid = 1'b0;
            if (k == 3) begin in_valid = 1'b1; op = 3'd0; A = 8'h01; B = 8'h01; end
            if (k == 4) in_valid = 1'b0;
        end
        chk("mul_busy_cycles", busy_cnt, 8);
        chk("mul_latency", ov_at, 9);

        // Reset in the middle of a MUL aborts it with no out_valid
        issue(3'd7, 8'h03, 8'h05, 1'b0, mk(8'h0F, 1'b0, 1'b0), 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("abort_R", R, 0);
        chk("abort_flags", {zero, c_out, sign, ovf}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        ov_before = ov_seen;
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_ov", ov_seen - ov_before, 0);
`else
        // Without the multiplier, op 111 is a single-cycle NOT
        issue(3'd7, 8'h5A, 8'h00, 1'b0, mk(8'hA5, 1'b0, 1'b0), 1);
        idle();
        chk("not_out_valid", out_valid, 1);
        chk("not_busy_tied", busy, 0);
        chk("not_in_ready", in_ready, 1);
        @(negedge clk);
`endif

        // NEG of the most negative value
        issue(3'd3, 8'h80, 8'h00, 1'b0, mk(8'h80, 1'b0, 1'b1), 1);
        idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
